// File: rtl/mtm_alu_serializer.sv
// rtl/mtm_alu_serializer.sv - ALU result/error frame serializer using 11-bit start/type/payload/stop packets
module mtm_alu_serializer #(
    parameter int CRC_WIDTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic [31:0] C,
    input  logic [3:0]  flags,
    input  logic        err,
    input  logic [5:0]  err_flags,
    output logic        busy,
    output logic        sout
);

    typedef enum logic [1:0] {
        IDLE,
        SEND_DATA,
        SEND_CTL
    } state_t;

    state_t      state;
    logic [3:0]  bit_cnt;
    logic [1:0]  pkt_cnt;
    logic [9:0]  shift;
    logic [23:0] data;
    logic [7:0]  ctl;
    logic [7:0]  next_ctl;

    // Serial LFSR for x^3+x+1, zero seed, message fed MSB first
    function automatic logic [CRC_WIDTH-1:0] crc3(input logic [36:0] msg);
        logic [CRC_WIDTH-1:0] r;
        logic [36:0]          m;
        logic                 fb;
        r = '0;
        m = msg;
        for (int i = 0; i < 37; i++) begin
            fb = r[2] ^ m[36];
            r  = {r[1], r[0] ^ fb, fb};
            m  = {m[35:0], 1'b0};
        end
        return r;
    endfunction

    always_comb begin
        next_ctl = 8'h00;
        if (err)
            next_ctl = {1'b1, err_flags, ^{1'b1, err_flags}};
        else
            next_ctl = {1'b0, flags, crc3({C, 1'b0, flags})};
    end

    // shift holds the bits still to go after the start bit: {type, payload, stop}
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            sout    <= 1'b1;
            bit_cnt <= 4'd0;
            pkt_cnt <= 2'd0;
            shift   <= 10'd0;
            data    <= 24'd0;
            ctl     <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    sout <= 1'b1;
                    busy <= 1'b0;
                    if (valid) begin
                        busy    <= 1'b1;
                        sout    <= 1'b0;
                        bit_cnt <= 4'd0;
                        pkt_cnt <= 2'd0;
                        data    <= C[23:0];
                        ctl     <= next_ctl;
                        if (err) begin
                            state <= SEND_CTL;
                            shift <= {1'b1, next_ctl, 1'b1};
                        end else begin
                            state <= SEND_DATA;
                            shift <= {1'b0, C[31:24], 1'b1};
                        end
                    end
                end
                SEND_DATA: begin
                    if (bit_cnt == 4'd10) begin
                        bit_cnt <= 4'd0;
                        sout    <= 1'b0;
                        if (pkt_cnt == 2'd3) begin
                            state <= SEND_CTL;
                            shift <= {1'b1, ctl, 1'b1};
                        end else begin
                            pkt_cnt <= pkt_cnt + 2'd1;
                            shift   <= {1'b0, data[23:16], 1'b1};
                            data    <= {data[15:0], 8'h00};
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        sout    <= shift[9];
                        shift   <= {shift[8:0], 1'b0};
                    end
                end
                SEND_CTL: begin
                    if (bit_cnt == 4'd10) begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        sout    <= 1'b1;
                        bit_cnt <= 4'd0;
                    end else begin
                        bit_cnt <= bit_cnt + 4'd1;
                        sout    <= shift[9];
                        shift   <= {shift[8:0], 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// tb/tb_mtm_alu_serializer.sv - scoreboard bench for mtm_alu_serializer
module tb_mtm_alu_serializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [31:0] C;
    logic [3:0]  flags;
    logic        err;
    logic [5:0]  err_flags;
    logic        busy;
    logic        sout;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0] bits;
        int          len;
    } frame_t;

    frame_t exp_q[$];

    mtm_alu_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .C         (C),
        .flags     (flags),
        .err       (err),
        .err_flags (err_flags),
        .busy      (busy),
        .sout      (sout)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Long division of the augmented message by 1011
    function automatic logic [2:0] ref_crc(input logic [31:0] c, input logic [3:0] f);
        logic [39:0] m;
        m = {c, 1'b0, f, 3'b000};
        for (int i = 39; i >= 3; i--)
            if (m[i]) m[i-:4] = m[i-:4] ^ 4'b1011;
        return m[2:0];
    endfunction

    function automatic logic [10:0] pkt(input logic t, input logic [7:0] p);
        return {1'b0, t, p, 1'b1};
    endfunction

    function automatic frame_t result_frame(input logic [31:0] c, input logic [3:0] f);
        frame_t fr;
        fr.bits = {9'd0, pkt(1'b0, c[31:24]), pkt(1'b0, c[23:16]), pkt(1'b0, c[15:8]),
                   pkt(1'b0, c[7:0]), pkt(1'b1, {1'b0, f, ref_crc(c, f)})};
        fr.len  = 55;
        return fr;
    endfunction

    function automatic frame_t error_frame(input logic [5:0] e);
        frame_t fr;
        logic   p;
        p       = ($countones({1'b1, e}) % 2) == 1;
        fr.bits = {53'd0, pkt(1'b1, {1'b1, e, p})};
        fr.len  = 11;
        return fr;
    endfunction

    // Waits (bounded) for busy, then records sout for every busy cycle
    task automatic collect(output logic [63:0] bits, output int len, output logic idle_sout,
                           output int waits, input int budget);
        bits = '0;
        len = 0;
        waits = 0;
        idle_sout = 1'bx;
        while (busy !== 1'b1 && waits < budget) begin
            @(negedge clk);
            waits++;
        end
        if (busy === 1'b1) begin
            while (busy === 1'b1 && len < 70) begin
                bits = {bits[62:0], sout};
                len++;
                @(negedge clk);
            end
            idle_sout = sout;
        end
    endtask

    task automatic send_one(input logic [31:0] c, input logic [3:0] f, input logic e,
                            input logic [5:0] ef);
        @(negedge clk);
        valid = 1'b1;
        C = c;
        flags = f;
        err = e;
        err_flags = ef;
        exp_q.push_back(e ? error_frame(ef) : result_frame(c, f));
        @(negedge clk);
        valid = 1'b0;
        C = $urandom;
        flags = 4'($urandom);
        err_flags = 6'($urandom);
        err = 1'($urandom);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        valid = 1'b0;
        C = '0;
        flags = '0;
        err = 1'b0;
        err_flags = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            checks++;
            if (sout !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle sout=%b busy=%b required sout=1 busy=0", sout, busy);
            end
        end
    endtask

    task automatic test_result(input logic [31:0] c, input logic [3:0] f);
        logic [63:0] bits;
        int          len, waits;
        logic        idle;
        frame_t      ex;
        send_one(c, f, 1'b0, 6'd0);
        collect(bits, len, idle, waits, 10);
        ex = exp_q.pop_front();
        checks++;
        if (bits !== ex.bits || len != ex.len) begin
            errors++;
            $display("FAIL result_frame c=%h got %h len %0d required %h len %0d", c, bits, len, ex.bits, ex.len);
        end
        checks++;
        if (waits != 0 || idle !== 1'b1) begin
            errors++;
            $display("FAIL result_latency c=%h got waits %0d idle %b required 0 and 1", c, waits, idle);
        end
    endtask

    task automatic test_zero_result;
        test_result(32'h0, 4'h0);
    endtask

    task automatic test_byte_order;
        test_result(32'h12345678, 4'b0010);
        for (int i = 0; i < 4; i++) test_result($urandom, 4'($urandom));
    endtask

    task automatic test_error_frames;
        logic [63:0] bits;
        int          len, waits;
        logic        idle;
        frame_t      ex;
        logic [5:0]  codes[2] = '{6'b100100, 6'b010010};
        logic [10:0] lit[2]   = '{11'b0_1_11001001_1, 11'b0_1_10100101_1};
        for (int i = 0; i < 2; i++) begin
            send_one($urandom, 4'($urandom), 1'b1, codes[i]);
            collect(bits, len, idle, waits, 10);
            ex = exp_q.pop_front();
            checks++;
            if (bits !== ex.bits || len != 11 || waits != 0) begin
                errors++;
                $display("FAIL error_frame code=%b got %h len %0d waits %0d required %h len 11 waits 0",
                         codes[i], bits, len, waits, ex.bits);
            end
            checks++;
            if (bits[10:0] !== lit[i]) begin
                errors++;
                $display("FAIL error_ctl_literal got %b required %b", bits[10:0], lit[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [63:0] b1, b2;
        int          l1, l2, w1, w2;
        logic        i1, i2;
        int          stray;
        frame_t      e1, e2;
        fork
            begin
                @(negedge clk);
                valid = 1'b1;
                err = 1'b0;
                C = 32'hDEADBEEF;
                flags = 4'b1001;
                exp_q.push_back(result_frame(32'hDEADBEEF, 4'b1001));
                @(negedge clk);
                C = 32'hA5C30F81;
                flags = 4'b0110;
                exp_q.push_back(result_frame(32'hA5C30F81, 4'b0110));
                repeat (59) @(negedge clk);
                valid = 1'b0;
                C = $urandom;
                err = 1'b1;
                @(negedge clk);
                valid = 1'b1;
                @(negedge clk);
                valid = 1'b0;
                err = 1'b0;
            end
            begin
                collect(b1, l1, i1, w1, 10);
                collect(b2, l2, i2, w2, 10);
            end
        join
        e1 = exp_q.pop_front();
        e2 = exp_q.pop_front();
        checks++;
        if (b1 !== e1.bits || l1 != 55) begin
            errors++;
            $display("FAIL b2b_frame1 got %h len %0d required %h len 55", b1, l1, e1.bits);
        end
        checks++;
        if (i1 !== 1'b1 || w2 != 1) begin
            errors++;
            $display("FAIL b2b_gap got idle_sout %b gap %0d required 1 and 1", i1, w2);
        end
        checks++;
        if (b2 !== e2.bits || l2 != 55) begin
            errors++;
            $display("FAIL b2b_frame2 got %h len %0d required %h len 55", b2, l2, e2.bits);
        end
        stray = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy !== 1'b0 || sout !== 1'b1) stray++;
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL b2b_no_extra_frame got %0d busy cycles required 0", stray);
        end
    endtask

    task automatic test_reset_mid_frame;
        @(negedge clk);
        valid = 1'b1;
        err = 1'b0;
        C = 32'hCAFEF00D;
        flags = 4'b1111;
        @(negedge clk);
        valid = 1'b0;
        repeat (14) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midframe_busy got %b required 1", busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (sout !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midframe_reset sout=%b busy=%b required sout=1 busy=0", sout, busy);
        end
        @(negedge clk);
        checks++;
        if (sout !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midframe_after sout=%b busy=%b required sout=1 busy=0", sout, busy);
        end
        test_result(32'h0F1E2D3C, 4'b0101);
    endtask

    initial begin
        test_reset;
        test_zero_result;
        test_byte_order;
        test_error_frames;
        test_back_to_back;
        test_reset_mid_frame;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d left required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
